// File: rtl/audio_pkg.sv
// Shared audio constants for the mic level meter and the OLED volume display.
package audio_pkg;
  localparam int MIC_W        = 12;
  localparam int LEVEL_W      = 4;
  localparam int LEVEL_SHIFT  = 7;
  localparam int LEVEL_MAX    = 15;
  localparam int BASELINE_DEF = 2048;
endpackage

// File: rtl/level_quant.sv
// Peak-to-level quantizer: subtract the mid-rail, shift down, saturate.
// Purely combinational, no backpressure.
module level_quant
  import audio_pkg::*;
(
  input  logic [MIC_W-1:0]   i_win_peak,
  input  logic [MIC_W-1:0]   i_baseline,
  output logic [LEVEL_W-1:0] o_q
);

  logic [MIC_W-1:0] w_amp;
  logic [MIC_W-1:0] w_shifted;

  assign w_amp     = (i_win_peak > i_baseline) ? (i_win_peak - i_baseline) : '0;
  assign w_shifted = w_amp >> LEVEL_SHIFT;
  assign o_q       = (w_shifted > MIC_W'(LEVEL_MAX)) ? LEVEL_W'(LEVEL_MAX)
                                                     : w_shifted[LEVEL_W-1:0];

endmodule

// File: rtl/mic_peak_level.sv
// Windowed mic peak detector producing a 0..15 level; outputs update on the closing strobe's edge.
// No input backpressure: every sample_valid is accepted. Slow-fall hold enabled by MIC_LEVEL_HOLD_EN.
module mic_peak_level
  import audio_pkg::*;
#(
  parameter int               WINDOW   = 4000,
  parameter logic [MIC_W-1:0] BASELINE = MIC_W'(BASELINE_DEF)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               sample_valid,
  input  logic [MIC_W-1:0]   mic_in,
  output logic [LEVEL_W-1:0] level,
  output logic               level_valid,
  output logic [MIC_W-1:0]   peak
);

  logic [15:0]        r_cnt;
  logic [MIC_W-1:0]   r_acc_max;
  logic [MIC_W-1:0]   r_peak;
  logic [LEVEL_W-1:0] r_level;
  logic               r_level_valid;

  logic [MIC_W-1:0]   w_win_peak;
  logic               w_close;
  logic [LEVEL_W-1:0] w_q;
  logic [LEVEL_W-1:0] w_next_level;

  // The closing sample takes part in its own window's maximum.
  assign w_win_peak = (mic_in > r_acc_max) ? mic_in : r_acc_max;
  assign w_close    = sample_valid && (r_cnt == 16'(WINDOW - 1));

  level_quant u_quant (
    .i_win_peak (w_win_peak),
    .i_baseline (BASELINE),
    .o_q        (w_q)
  );

`ifdef MIC_LEVEL_HOLD_EN
  // q >= 0 always holds, so the decrement branch never sees level == 0.
  assign w_next_level = (w_q >= r_level) ? w_q : (r_level - LEVEL_W'(1));
`else
  assign w_next_level = w_q;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      r_cnt         <= '0;
      r_acc_max     <= '0;
      r_peak        <= '0;
      r_level       <= '0;
      r_level_valid <= 1'b0;
    end else begin
      r_level_valid <= 1'b0;
      if (sample_valid) begin
        r_acc_max <= (r_cnt == '0) ? mic_in : w_win_peak;
        if (w_close) begin
          r_cnt         <= '0;
          r_peak        <= w_win_peak;
          r_level       <= w_next_level;
          r_level_valid <= 1'b1;
        end else begin
          r_cnt <= r_cnt + 16'd1;
        end
      end
    end
  end

  assign level       = r_level;
  assign level_valid = r_level_valid;
  assign peak        = r_peak;

endmodule

// File: tb/tb_mic_peak_level.sv
// Self-checking bench for mic_peak_level with WINDOW=4.
module tb_mic_peak_level;

  logic        clk;
  logic        rst;
  logic        sample_valid;
  logic [11:0] mic_in;
  logic [3:0]  level;
  logic        level_valid;
  logic [11:0] peak;

  mic_peak_level #(.WINDOW(4), .BASELINE(12'd2048)) dut (
    .clk          (clk),
    .rst          (rst),
    .sample_valid (sample_valid),
    .mic_in       (mic_in),
    .level        (level),
    .level_valid  (level_valid),
    .peak         (peak)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [3:0][11:0] s;
    logic             gap;
    logic [11:0]      exp_peak;
    logic [3:0]       exp_q;
  } vec_t;

  typedef struct {
    logic [11:0] pk;
    logic [3:0]  lv;
    int          due;
  } exp_t;

  vec_t vecs [13];
  exp_t sb [$];
  int   errors = 0;
  int   checks = 0;
  logic [3:0]  m_lvl  = 4'd0;
  logic [11:0] m_peak = 12'd0;

  function automatic vec_t mk(input logic [11:0] a, input logic [11:0] b,
                              input logic [11:0] c, input logic [11:0] d,
                              input logic g, input logic [11:0] pk, input logic [3:0] q);
    vec_t v;
    v.s[0] = a; v.s[1] = b; v.s[2] = c; v.s[3] = d;
    v.gap = g; v.exp_peak = pk; v.exp_q = q;
    return v;
  endfunction

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic send(input logic v, input logic [11:0] d);
    @(posedge clk);
    #1;
    sample_valid = v;
    mic_in       = d;
  endtask

  task automatic run_window(input vec_t v);
    exp_t e;
    for (int k = 0; k < 4; k++) begin
      if (v.gap) send(1'b0, 12'hABC);
      send(1'b1, v.s[k]);
    end
`ifdef MIC_LEVEL_HOLD_EN
    m_lvl = (v.exp_q >= m_lvl) ? v.exp_q : m_lvl - 4'd1;
`else
    m_lvl = v.exp_q;
`endif
    m_peak = v.exp_peak;
    e.pk = v.exp_peak; e.lv = m_lvl; e.due = cyc + 1;
    sb.push_back(e);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, errors=%0d", errors);
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; sample_valid = 1'b0; mic_in = '0;
    vecs[0]  = mk(12'd2048, 12'd2100, 12'd3000, 12'd2500, 1'b0, 12'd3000, 4'd7);
    vecs[1]  = mk(12'd4095, 12'd4095, 12'd4095, 12'd4095, 1'b1, 12'd4095, 4'd15);
    vecs[2]  = mk(12'd1000, 12'd1000, 12'd1000, 12'd1000, 1'b0, 12'd1000, 4'd0);
    vecs[3]  = mk(12'd2048, 12'd2048, 12'd2048, 12'd4000, 1'b0, 12'd4000, 4'd15);
    vecs[4]  = mk(12'd2048, 12'd2048, 12'd2048, 12'd2048, 1'b0, 12'd2048, 4'd0);
    vecs[5]  = mk(12'd4095, 12'd4095, 12'd4095, 12'd4095, 1'b0, 12'd4095, 4'd15);
    vecs[6]  = mk(12'd1000, 12'd1000, 12'd1000, 12'd1000, 1'b1, 12'd1000, 4'd0);
    vecs[7]  = mk(12'd2048, 12'd2048, 12'd2048, 12'd2048, 1'b0, 12'd2048, 4'd0);
    vecs[8]  = mk(12'd2176, 12'd2000, 12'd2000, 12'd2000, 1'b0, 12'd2176, 4'd1);
    vecs[9]  = mk(12'd2000, 12'd2175, 12'd2000, 12'd2000, 1'b1, 12'd2175, 4'd0);
    vecs[10] = mk(12'd2048, 12'd3968, 12'd2048, 12'd2048, 1'b0, 12'd3968, 4'd15);
    vecs[11] = mk(12'd3967, 12'd100, 12'd2048, 12'd0, 1'b0, 12'd3967, 4'd14);
    vecs[12] = mk(12'd0, 12'd0, 12'd0, 12'd0, 1'b0, 12'd0, 4'd0);

    // Scoreboard monitor: every level_valid must match a queued window close.
    fork
      forever begin
        @(negedge clk);
        if (sb.size() > 0 && sb[0].due == cyc) begin
          chk("level_valid_timing", int'(level_valid), 1);
          chk("peak", int'(peak), int'(sb[0].pk));
          chk("level", int'(level), int'(sb[0].lv));
          void'(sb.pop_front());
        end else if (level_valid) begin
          chk("unexpected_level_valid", 1, 0);
        end
      end
    join_none

    // Reset held two cycles with strobes present.
    send(1'b1, 12'd4095);
    send(1'b1, 12'd4095);
    @(negedge clk);
    chk("rst_level", int'(level), 0);
    chk("rst_peak", int'(peak), 0);
    chk("rst_level_valid", int'(level_valid), 0);
    send(1'b0, 12'd0);
    rst = 1'b0;

    for (int i = 0; i < 13; i++) begin
      run_window(vecs[i]);
      if (i == 0 || i == 5) begin
        for (int k = 0; k < 3; k++) send(1'b0, 12'd4095);
        @(negedge clk);
        chk("hold_level_between", int'(level), int'(m_lvl));
        chk("hold_peak_between", int'(peak), int'(m_peak));
      end
    end

    // Loud window after a partial window, then a mid-window reset.
    send(1'b0, 12'd0);
    run_window(vecs[1]);
    for (int k = 0; k < 3; k++) send(1'b1, 12'd4095);
    send(1'b0, 12'd0);
    rst = 1'b1;
    send(1'b1, 12'd4095);
    rst = 1'b0;
    sample_valid = 1'b0;
    m_lvl = 4'd0;
    @(negedge clk);
    chk("midrst_level", int'(level), 0);
    chk("midrst_peak", int'(peak), 0);
    run_window(vecs[4]);

    for (int k = 0; k < 6; k++) send(1'b0, 12'd0);
    @(negedge clk);
    chk("scoreboard_drained", sb.size(), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/mic_peak_level.md
# mic_peak_level

Converts the 12-bit microphone sample stream into a 4-bit volume level (0–15) once per fixed window of samples. It sits directly upstream of the LED bar-graph stage and drives that stage's `num` input. It also feeds the OLED volume display. Internally it tracks the peak over each window, quantizes the peak above the mic's mid-rail, and optionally applies a slow-fall hold.

## Interface
Parameters:
- `WINDOW`, default 4000: samples per measurement window (0.2 s at 20 kHz); legal range 2..65535.
- `BASELINE`, default 2048: mic mid-rail code; samples at or below it count as silence.

Ports:
- `clk`  in  1  system clock (100 MHz); the only clock.
- `rst`  in  1  synchronous, active-high reset.
- `sample_valid`  in  1  one-cycle strobe; `mic_in` is valid on this cycle.
- `mic_in`  in  12  unsigned mic sample.
- `level`  out  4  current volume level, registered; drives the bar-graph `num`.
- `level_valid`  out  1  one-cycle pulse when `level` has just updated.
- `peak`  out  12  registered max sample of the last completed window.

## Operation
- `cnt[15:0]` counts accepted samples within the window, from 0 to WINDOW-1. `acc_max[11:0]` holds the running max.
- Accumulation happens on each `sample_valid`:
  - If `cnt == 0`, `acc_max <= mic_in` (a load, not a compare).
  - Otherwise, `acc_max <= max(acc_max, mic_in)`.
- Window close happens on the `sample_valid` with `cnt == WINDOW-1`:
  - `win_peak = max(acc_max, mic_in)`, so the closing sample is included.
  - `peak <= win_peak`.
  - `level <= q` (or the held value; see Configuration).
  - `level_valid <= 1`.
  - `cnt <= 0`.
- Otherwise, `cnt <= cnt + 1` on each `sample_valid`. `cnt` does not move without `sample_valid`.
- Quantization:
  - `amp = (win_peak > BASELINE) ? win_peak - BASELINE : 0`, held in 12 bits.
  - `q = amp >> 7`, saturated to 15.
  - Amplitudes 0..127 give 0. 1920 and above gives 15.
- `level` and `peak` hold their values between windows.
- `level_valid` is 0 on every cycle that is not a window close.
- Back-to-back `sample_valid` on consecutive clocks is legal and is accepted every cycle.

## Timing
- Reset state: `cnt = 0`, `acc_max = 0`, `level = 0`, `peak = 0`, `level_valid = 0`, hold register = 0.
- Reset has priority over `sample_valid` in the same cycle. A reset mid-window discards the partial window, and the next sample starts a new window at `cnt = 0`.
- Latency: `level`, `peak` and `level_valid` update on the clock edge that samples the closing `sample_valid`. They are visible one cycle after the strobe.
- There is no input backpressure. Samples are never dropped.

## Configuration
- `MIC_LEVEL_HOLD_EN` defined:
  - At each window close, if `q >= level`, `level <= q` (instant attack).
  - Otherwise `level <= level - 1` (fall of one step per window).
  - `level_valid` still pulses every window.
- Not defined:
  - `level <= q` every window, with no hold register.
- `peak` is unaffected by the macro in both cases.

## Structure
- Shared package `audio_pkg` holds the constants:
  - `MIC_W = 12`
  - `LEVEL_W = 4`
  - `LEVEL_SHIFT = 7`
  - `LEVEL_MAX = 15`
  - default `BASELINE`
- One natural sub-module, `level_quant`: combinational `win_peak` and `BASELINE` in, `q` out (subtract, shift, saturate). It is reused by the OLED meter.
- The counter, max accumulator and hold logic stay in the top module.

## Test plan
- Reset: assert `rst` for 2 cycles with strobes present → `level = 0`, `peak = 0`, `level_valid = 0`. The first window then completes after exactly WINDOW strobes.
- Quantization (WINDOW=4): samples 2048, 2100, 3000, 2500 → `peak = 3000`, `level = 7` (952 >> 7), one `level_valid` pulse one cycle after the 4th strobe.
- Saturation and silence (WINDOW=4):
  - Four samples of 4095 → `level = 15`, `peak = 4095`.
  - Four samples of 1000 → `level = 0`, `peak = 1000`.
- Closing sample and back-to-back strobes (WINDOW=4): strobes on 4 consecutive clocks with 2048, 2048, 2048, 4000 → `peak = 4000`, `level = 15`. The next window's first sample 2048 loads `acc_max` (no carry-over), so the next `peak` is 2048 if all samples are 2048.
- Hold (`MIC_LEVEL_HOLD_EN`, WINDOW=4):
  - Window at level 15, then silent windows → `level` goes 15, 14, 13, … one step per window.
  - A loud window mid-decay jumps straight to 15.
  - Without the macro, the first silent window gives `level = 0`.
- Reset mid-window (WINDOW=4): 3 samples of 4095, then `rst`, then 4 samples of 2048 → `peak = 2048`, `level = 0`. The pre-reset samples are discarded.
